// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Tracks general-purpose registers awaiting a long-latency producer
//            (loads, pre/post-increment memory ops). Stalls decode when a
//            source or destination register is still pending. Also caps the
//            number of outstanding long-latency writes at MAX_OUT.
//
// Ports    : clk            in   clock, all state on rising edge
//            rst_n          in   synchronous active-low reset
//            issue_valid    in   decode presents an instruction
//            issue_long     in   rd written by a long-latency producer
//            issue_rd       in   [4:0] destination register
//            issue_ra/rb    in   [4:0] source registers
//            issue_use_ra/rb in  source actually read
//            complete_valid in   long-latency result written this cycle
//            complete_rd    in   [4:0] register being completed
//            flush          in   cancel all pending producers
//            stall          out  combinational decode hold
//            busy_mask      out  [31:0] registered pending-register bitmap
//            outstanding    out  registered count of pending producers
//            err_spurious   out  sticky: completion for a non-busy register
//
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
   parameter int MAX_OUT = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         issue_valid,
   input  logic                         issue_long,
   input  logic [4:0]                   issue_rd,
   input  logic [4:0]                   issue_ra,
   input  logic [4:0]                   issue_rb,
   input  logic                         issue_use_ra,
   input  logic                         issue_use_rb,
   input  logic                         complete_valid,
   input  logic [4:0]                   complete_rd,
   input  logic                         flush,
   output logic                         stall,
   output logic [31:0]                  busy_mask,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         err_spurious
);

   localparam int              C_OW  = $clog2(MAX_OUT + 1);
   localparam logic [C_OW-1:0] C_MAX = C_OW'(MAX_OUT);

   logic            w_hazard;
   logic            w_full;
   logic            w_long_rd;
   logic            w_accept;
   logic            w_cmp_hit;
   logic            w_cmp_spur;
   logic [31:0]     w_set_mask;
   logic [31:0]     w_clr_mask;
   logic [31:0]     w_busy_nxt;
   logic [C_OW-1:0] w_out_nxt;

   // Bit 0 of busy_mask is never set, so r0 references can never hazard and
   // completions to r0 fall into the spurious path automatically.
   assign w_long_rd = issue_long & (issue_rd != 5'd0);

   assign w_hazard  = issue_valid & ((issue_use_ra & busy_mask[issue_ra]) |
                                     (issue_use_rb & busy_mask[issue_rb]) |
                                     busy_mask[issue_rd]);
   assign w_full    = issue_valid & w_long_rd & (outstanding == C_MAX);

   // No term from complete_valid: a reader in the completion cycle would see
   // stale register-file data, so dependents wait one more cycle.
   assign stall     = (w_hazard | w_full) & ~flush;

   assign w_accept  = issue_valid & ~stall & w_long_rd & ~flush;
   assign w_cmp_hit = complete_valid &  busy_mask[complete_rd];
   assign w_cmp_spur = complete_valid & ~busy_mask[complete_rd];

   assign w_set_mask = w_accept  ? (32'd1 << issue_rd)    : 32'd0;
   assign w_clr_mask = w_cmp_hit ? (32'd1 << complete_rd) : 32'd0;

   // Set and clear never target the same register: the WAW term stalls any
   // issue whose rd is still busy.
   assign w_busy_nxt = (busy_mask | w_set_mask) & ~w_clr_mask;

   always_comb begin
      w_out_nxt = outstanding;
      case ({w_accept, w_cmp_hit})
         2'b10:   w_out_nxt = outstanding + C_OW'(1);
         2'b01:   w_out_nxt = outstanding - C_OW'(1);
         default: w_out_nxt = outstanding;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_mask    <= 32'd0;
         outstanding  <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (flush) begin
            busy_mask   <= 32'd0;
            outstanding <= '0;
         end else begin
            busy_mask   <= w_busy_nxt;
            outstanding <= w_out_nxt;
         end
         if (w_cmp_spur && !flush) begin
            err_spurious <= 1'b1;
         end
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      outstanding <= C_MAX);

   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      (w_cmp_hit && !w_accept && !flush) |-> (outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Directed self-checking bench for reg_scoreboard (MAX_OUT = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_long;
   logic [4:0]  issue_rd;
   logic [4:0]  issue_ra;
   logic [4:0]  issue_rb;
   logic        issue_use_ra;
   logic        issue_use_rb;
   logic        complete_valid;
   logic [4:0]  complete_rd;
   logic        flush;
   logic        stall;
   logic [31:0] busy_mask;
   logic [2:0]  outstanding;
   logic        err_spurious;

   int checks = 0;
   int errors = 0;

   reg_scoreboard #(.MAX_OUT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid    (issue_valid),
      .issue_long     (issue_long),
      .issue_rd       (issue_rd),
      .issue_ra       (issue_ra),
      .issue_rb       (issue_rb),
      .issue_use_ra   (issue_use_ra),
      .issue_use_rb   (issue_use_rb),
      .complete_valid (complete_valid),
      .complete_rd    (complete_rd),
      .flush          (flush),
      .stall          (stall),
      .busy_mask      (busy_mask),
      .outstanding    (outstanding),
      .err_spurious   (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and outputs
   // sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic lng, input logic [4:0] rd,
                        input logic [4:0] ra, input logic ua,
                        input logic [4:0] rb, input logic ub);
      issue_valid  = 1'b1;
      issue_long   = lng;
      issue_rd     = rd;
      issue_ra     = ra;
      issue_use_ra = ua;
      issue_rb     = rb;
      issue_use_rb = ub;
   endtask

   task automatic idle();
      issue_valid  = 1'b0;
      issue_long   = 1'b0;
      issue_rd     = 5'd0;
      issue_ra     = 5'd0;
      issue_rb     = 5'd0;
      issue_use_ra = 1'b0;
      issue_use_rb = 1'b0;
   endtask

   initial begin
      idle();
      rst_n          = 1'b0;
      complete_valid = 1'b0;
      complete_rd    = 5'd0;
      flush          = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_busy", busy_mask, 32'h0);
      chk("rst_out", 32'(outstanding), 32'd0);
      chk("rst_err", 32'(err_spurious), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;

      // Load to r5, dependent reader stalls through the completion cycle
      issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("ld5_stall", 32'(stall), 32'd0);
      step();
      chk("ld5_busy", busy_mask, 32'h0000_0020);
      chk("ld5_out", 32'(outstanding), 32'd1);
      issue(1'b0, 5'd1, 5'd5, 1'b1, 5'd0, 1'b0);
      #1 chk("use5_stall", 32'(stall), 32'd1);
      step();
      complete_valid = 1'b1;
      complete_rd    = 5'd5;
      #1 chk("use5_cmp_stall", 32'(stall), 32'd1);
      step();
      complete_valid = 1'b0;
      #1 chk("use5_after_stall", 32'(stall), 32'd0);
      chk("use5_after_busy", busy_mask, 32'h0);
      chk("use5_after_out", 32'(outstanding), 32'd0);
      step();
      idle();

      // Fill to MAX_OUT with r1..r4, fifth long op to r6 blocks
      for (int r = 1; r <= 4; r++) begin
         issue(1'b1, 5'(r), 5'd0, 1'b0, 5'd0, 1'b0);
         step();
      end
      chk("fill_out", 32'(outstanding), 32'd4);
      chk("fill_busy", busy_mask, 32'h0000_001E);
      issue(1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("full_stall", 32'(stall), 32'd1);
      complete_valid = 1'b1;
      complete_rd    = 5'd2;
      #1 chk("full_cmp_stall", 32'(stall), 32'd1);
      step();
      complete_valid = 1'b0;
      chk("full_cmp_out", 32'(outstanding), 32'd3);
      chk("full_free_stall", 32'(stall), 32'd0);
      step();
      idle();
      chk("fifth_out", 32'(outstanding), 32'd4);
      chk("fifth_busy", busy_mask, 32'h0000_005A);

      // Free a slot, then accept r7 while completing r3 in the same cycle
      complete_valid = 1'b1;
      complete_rd    = 5'd1;
      step();
      chk("cmp1_out", 32'(outstanding), 32'd3);
      complete_rd = 5'd3;
      issue(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("same_stall", 32'(stall), 32'd0);
      step();
      complete_valid = 1'b0;
      idle();
      chk("same_busy", busy_mask, 32'h0000_00D0);
      chk("same_out", 32'(outstanding), 32'd3);
      chk("same_err", 32'(err_spurious), 32'd0);

      // Flush clears everything
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", busy_mask, 32'h0);
      chk("flush_out", 32'(outstanding), 32'd0);

      // rd = 0 long op and r0 reads never stall or count
      issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      #1 chk("r0_stall", 32'(stall), 32'd0);
      step();
      idle();
      chk("r0_out", 32'(outstanding), 32'd0);
      chk("r0_busy", busy_mask, 32'h0);

      // WAW on r9, then flush in the same cycle masks the stall
      issue(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      chk("r9_busy", busy_mask, 32'h0000_0200);
      issue(1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("waw_stall", 32'(stall), 32'd1);
      flush          = 1'b1;
      complete_valid = 1'b1;
      complete_rd    = 5'd12;
      #1 chk("waw_flush_stall", 32'(stall), 32'd0);
      step();
      flush          = 1'b0;
      complete_valid = 1'b0;
      idle();
      chk("waw_flush_busy", busy_mask, 32'h0);
      chk("waw_flush_out", 32'(outstanding), 32'd0);
      chk("waw_flush_err", 32'(err_spurious), 32'd0);

      // Spurious completion sets a sticky error cleared only by reset
      complete_valid = 1'b1;
      complete_rd    = 5'd12;
      step();
      complete_valid = 1'b0;
      chk("spur_err", 32'(err_spurious), 32'd1);
      chk("spur_out", 32'(outstanding), 32'd0);
      step();
      step();
      chk("spur_hold", 32'(err_spurious), 32'd1);
      rst_n = 1'b0;
      step();
      chk("spur_rst", 32'(err_spurious), 32'd0);
      rst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks general-purpose registers that are waiting on a long-latency producer: loads, and pre/post-increment memory operations whose data comes back late. It sits beside the 32-entry register file in decode. It stalls any instruction whose source or destination register is still pending, and it limits the number of outstanding long-latency writes. It gives the register file's single-edge write/read behaviour a safe sequencing rule without bypass.

## Interface
- MAX_OUT, default 4: maximum outstanding long-latency writes (2..15).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_long  in  1  the instruction's rd is written by a long-latency producer.
- issue_rd  in  5  destination register.
- issue_ra, issue_rb  in  5 each  source registers.
- issue_use_ra, issue_use_rb  in  1 each  the corresponding source is actually read.
- complete_valid  in  1  long-latency result is written to the register file this cycle.
- complete_rd  in  5  register being completed.
- flush  in  1  exception/redirect in writeback; cancel all pending producers.
- stall  out  1  combinational; hold decode this cycle.
- busy_mask  out  32  registered; bit i set when ri is pending.
- outstanding  out  clog2(MAX_OUT+1)  registered count of pending producers.
- err_spurious  out  1  registered, sticky; a completion arrived for a non-busy register.

## Operation
- r0 is never busy. issue_rd == 0 with issue_long allocates nothing and does not count.
- hazard = issue_valid & ((issue_use_ra & busy[ra]) | (issue_use_rb & busy[rb]) | busy[issue_rd]).
  - The busy[issue_rd] term is the WAW check.
  - Because r0 is never busy, a reference to r0 never hazards.
- full = issue_valid & issue_long & (issue_rd != 0) & (outstanding == MAX_OUT).
- stall = (hazard | full) & !flush.
- accept = issue_valid & !stall & issue_long & (issue_rd != 0) & !flush.
- On accept: set busy[issue_rd] and increment outstanding.
- On complete_valid with busy[complete_rd] set: clear the bit and decrement outstanding.
- On complete_valid with busy[complete_rd] clear, or complete_rd == 0:
  - ignore it; no state change;
  - set err_spurious unless flush is high that cycle.
- Accept and complete in the same cycle:
  - always on different registers, because the WAW check prevents the same register;
  - both take effect and outstanding is unchanged.
- flush:
  - clears busy_mask and outstanding to 0;
  - overrides any same-cycle accept or complete.
  - The memory subsystem guarantees cancelled producers never complete afterwards.
- outstanding never exceeds MAX_OUT and never underflows. Implementation asserts both in simulation.

## Timing
- Reset (rst_n low at an edge): busy_mask = 0, outstanding = 0, err_spurious = 0.
  - During reset, stall is driven from the cleared state.
- stall is a function of the current registered state and current inputs only. There is no dependency on complete_valid, so there is no same-cycle bypass.
  - The register file samples read data on the same edge its write commits, so a reader in the completion cycle would get stale data.
  - A dependent instruction therefore stalls through the completion cycle and issues on the following cycle.
- Minimum load-to-use: producer accepted at edge N. Completion at the earliest in cycle N+1. Dependent issues no earlier than cycle N+2.
- busy_mask and outstanding update one edge after accept, complete or flush.
- err_spurious sets one edge after the offending completion and clears only on reset.
- A flush coinciding with reset: reset wins (same result).

## Test plan
- Reset, then accept a load with rd=5. Next issue has ra=5, use_ra=1 -> stall=1. Complete rd=5 in cycle 3 -> stall stays 1 in cycle 3, becomes 0 in cycle 4, busy_mask=0.
- MAX_OUT=4: accept long ops to r1, r2, r3, r4 -> outstanding=4. A fifth long op to r6 -> stall=1. Complete r2 -> fifth op accepted the cycle after, outstanding=4, busy_mask=0x5A.
- Same cycle: accept long rd=7 and complete rd=3 (r3 busy) -> next cycle busy[7]=1, busy[3]=0, outstanding unchanged.
- Long op with rd=0, and an instruction reading r0 -> never stall, outstanding=0.
- r9 busy plus a non-long issue with rd=9 -> stall (WAW). Flush in the same cycle -> stall=0, next cycle busy_mask=0, outstanding=0, err_spurious=0.
- complete_valid with rd=12 while r12 is not busy -> err_spurious=1 next cycle and held. A later rst_n low -> cleared.
